cmdin_stream_monitor: RTL

Synthesizable, parametrised protocol monitor for the cmdin accelerator interconnect. It passively observes the AXI-Stream command channel that feeds the accelerators and parses every command: exec, periodic exec and HW-instrumentation setup. It reports framing, field and copy-optimisation violations through a sticky error register and counters instead of halting. It sits beside the cmdin interconnect output and can ship in debug bitstreams as well as in simulation.

---
 rtl/OmpSsManager.sv | 54 +++++
 rtl/cmdin_shadow_mem.sv | 51 +++++
 rtl/cmdin_stream_monitor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/OmpSsManager.sv
// ============================================================================
//  OmpSsManager : cmdin command codes, field positions, monitor enums
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package OmpSsManager;

    localparam logic [7:0] EXEC_TASK_CODE      = 8'h01;
    localparam logic [7:0] SETUP_HW_INST_CODE  = 8'h02;
    localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'h05;
    localparam logic [7:0] HWR_CMDOUT_ID_BYTE  = 8'h11;

    // Header word layout
    localparam int CMD_CODE_L   = 0;
    localparam int CMD_NARGS_L  = 8;
    localparam int CMD_COMPF_L  = 16;
    localparam int CMD_DESTID_L = 32;

    // Task-id word: nonzero top byte marks an accelerator-created task
    localparam int TID_ACC_L = 56;

    localparam int ARG_FLAG_L    = 0;
    localparam int ARG_FLAG_H    = 7;
    localparam int FLAG_COPY_IN  = 4;
    localparam int FLAG_COPY_OUT = 5;

    typedef enum logic [3:0] {
        ERR_NONE         = 4'd0,
        ERR_BAD_CODE     = 4'd1,
        ERR_BAD_DESTID   = 4'd2,
        ERR_EARLY_LAST   = 4'd3,
        ERR_MISSING_LAST = 4'd4,
        ERR_ARG_IDX      = 4'd5,
        ERR_NARGS        = 4'd6,
        ERR_ACC_NOARGS   = 4'd7,
        ERR_COPY_IN      = 4'd8,
        ERR_COPY_OUT     = 4'd9,
        ERR_TDEST        = 4'd10
    } err_code_e;

    typedef enum logic [2:0] {
        ST_HEADER  = 3'd0,
        ST_TID     = 3'd1,
        ST_PTID    = 3'd2,
        ST_PERIOD  = 3'd3,
        ST_ARGFLAG = 3'd4,
        ST_ARG     = 3'd5,
        ST_DRAIN   = 3'd6
    } parser_state_e;

endpackage

`default_nettype wire

// File: rtl/cmdin_shadow_mem.sv
// ============================================================================
//  cmdin_shadow_mem : per-(tdest, argIdx) last value / copy-out / valid table
//  Built only when COPY_OPT_CHECK_EN is defined.   Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifdef COPY_OPT_CHECK_EN
module cmdin_shadow_mem #(
    parameter int ENTRIES = 240,
    parameter int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [63:0]       rd_value,
    output logic              rd_copy_out,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [63:0]       wr_value,
    input  logic              wr_copy_out
);

    logic [63:0]        value_q    [ENTRIES];
    logic               copy_out_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    // Only the valid bits need reset; stale payload is masked by them
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            value_q[wr_addr]    <= wr_value;
            copy_out_q[wr_addr] <= wr_copy_out;
        end
    end

    assign rd_value    = value_q[rd_addr];
    assign rd_copy_out = copy_out_q[rd_addr];
    assign rd_valid    = valid_q[rd_addr];

endmodule
`endif

`default_nettype wire

// File: rtl/cmdin_stream_monitor.sv
// ============================================================================
//  cmdin_stream_monitor : passive cmdin AXI-Stream command protocol checker
//  Optional copy-optimisation checks: COPY_OPT_CHECK_EN.  Rev 1.0 : initial
// ============================================================================
`default_nettype none

module cmdin_stream_monitor
    import OmpSsManager::*;
#(
    parameter int NUM_ACCS  = 16,
    parameter int ACC_BITS  = $clog2(NUM_ACCS),
    parameter int MAX_ARGS  = 15,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [63:0]          cmdin_tdata,
    input  logic                 cmdin_tvalid,
    input  logic                 cmdin_tready,
    input  logic                 cmdin_tlast,
    input  logic [ACC_BITS-1:0]  cmdin_tdest,
    output logic [ACC_BITS-1:0]  dir_acc,
    output logic [3:0]           dir_arg,
    input  logic                 dir_in,
    input  logic                 dir_out,
    input  logic                 err_clr,
    output logic                 err_valid,
    output logic [3:0]           err_code,
    output logic [ACC_BITS-1:0]  err_dest,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          cmd_cnt
);

    parser_state_e        state_q, state_d;
    logic [7:0]           code_q, code_d, nargs_q, nargs_d, compf_q, compf_d;
    logic [7:0]           flag_q, flag_d;
    logic [ACC_BITS-1:0]  tdest_q, tdest_d, dir_acc_q, dir_acc_d;
    logic                 acc_task_q, acc_task_d;
    logic [3:0]           arg_idx_q, arg_idx_d, dir_arg_q, dir_arg_d;
    logic                 err_valid_q, err_valid_d;
    err_code_e            err_code_q, err_code_d;
    logic [ACC_BITS-1:0]  err_dest_q, err_dest_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          cmd_cnt_q, cmd_cnt_d;

    logic      w_beat, w_last, w_complete, w_sh_we, w_final;
    err_code_e w_err, w_copy_err;
    logic [7:0] w_hdr_code, w_hdr_nargs, w_arg_cnt;
    logic      w_hdr_legal;

    assign w_beat      = cmdin_tvalid & cmdin_tready;
    assign w_last      = cmdin_tlast;
    assign w_hdr_code  = cmdin_tdata[CMD_CODE_L +: 8];
    assign w_hdr_nargs = cmdin_tdata[CMD_NARGS_L +: 8];
    assign w_hdr_legal = (w_hdr_code == EXEC_TASK_CODE) || (w_hdr_code == EXEC_PERI_TASK_CODE) ||
                         (w_hdr_code == SETUP_HW_INST_CODE);
    assign w_arg_cnt   = {4'b0, arg_idx_q} + 8'd1;
    assign w_final     = (w_arg_cnt == nargs_q);

`ifdef COPY_OPT_CHECK_EN
    localparam int ENTRIES = NUM_ACCS * MAX_ARGS;
    localparam int ADDR_W  = $clog2(ENTRIES);

    logic [ADDR_W-1:0] w_sh_addr;
    logic [63:0]       w_rd_value;
    logic              w_rd_copy_out, w_rd_valid;

    assign w_sh_addr = ADDR_W'(32'(tdest_q) * 32'(MAX_ARGS) + 32'(arg_idx_q));

    cmdin_shadow_mem #(
        .ENTRIES (ENTRIES)
    ) u_shadow (
        .clk         (clk),
        .rstn        (rstn),
        .rd_addr     (w_sh_addr),
        .rd_value    (w_rd_value),
        .rd_copy_out (w_rd_copy_out),
        .rd_valid    (w_rd_valid),
        .wr_en       (w_sh_we),
        .wr_addr     (w_sh_addr),
        .wr_value    (cmdin_tdata),
        .wr_copy_out (flag_q[FLAG_COPY_OUT])
    );

    // Skipping the copy-in is only safe if the accelerator already holds this value
    always_comb begin
        w_copy_err = ERR_NONE;
        if (dir_in && !flag_q[FLAG_COPY_IN] && !(w_rd_valid && (w_rd_value == cmdin_tdata))) begin
            w_copy_err = ERR_COPY_IN;
        end else if (w_rd_valid && !w_rd_copy_out && dir_out && (w_rd_value != cmdin_tdata)) begin
            w_copy_err = ERR_COPY_OUT;
        end
    end

    assign dir_acc = dir_acc_q;
    assign dir_arg = dir_arg_q;

    logic unused_sink;
    assign unused_sink = ^{compf_q, flag_q};
`else
    assign w_copy_err = ERR_NONE;
    assign dir_acc    = '0;
    assign dir_arg    = '0;

    logic unused_sink;
    assign unused_sink = ^{compf_q, flag_q, cmdin_tdata[31:24], dir_acc_q, dir_arg_q,
                           dir_in, dir_out, w_sh_we};
`endif

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        nargs_d    = nargs_q;
        compf_d    = compf_q;
        tdest_d    = tdest_q;
        acc_task_d = acc_task_q;
        arg_idx_d  = arg_idx_q;
        flag_d     = flag_q;
        dir_acc_d  = dir_acc_q;
        dir_arg_d  = dir_arg_q;
        w_err      = ERR_NONE;
        w_complete = 1'b0;
        w_sh_we    = 1'b0;

        if (w_beat) begin
            case (state_q)
                ST_HEADER: begin
                    code_d     = w_hdr_code;
                    nargs_d    = w_hdr_nargs;
                    compf_d    = cmdin_tdata[CMD_COMPF_L +: 8];
                    tdest_d    = cmdin_tdest;
                    acc_task_d = 1'b0;
                    arg_idx_d  = '0;
                    if (!w_hdr_legal)                                  w_err = ERR_BAD_CODE;
                    else if ((w_hdr_code != SETUP_HW_INST_CODE) &&
                             (cmdin_tdata[CMD_DESTID_L +: 8] != HWR_CMDOUT_ID_BYTE))
                                                                       w_err = ERR_BAD_DESTID;
                    else if (32'(w_hdr_nargs) > 32'(MAX_ARGS))         w_err = ERR_NARGS;
                    else if (32'(cmdin_tdest) >= 32'(NUM_ACCS))        w_err = ERR_TDEST;
                    else if (w_last)                                   w_err = ERR_EARLY_LAST;
                    state_d = ST_TID;
                end
                ST_TID: begin
                    acc_task_d = (cmdin_tdata[TID_ACC_L +: 8] != 8'd0);
                    if (acc_task_d && (code_q != EXEC_TASK_CODE))      w_err = ERR_BAD_CODE;
                    else if (code_q == SETUP_HW_INST_CODE) begin
                        if (!w_last) w_err = ERR_MISSING_LAST;
                        else         w_complete = 1'b1;
                    end else if (w_last)                               w_err = ERR_EARLY_LAST;
                    state_d = (code_q == SETUP_HW_INST_CODE) ? ST_HEADER : ST_PTID;
                end
                ST_PTID: begin
                    if (code_q == EXEC_PERI_TASK_CODE || nargs_q != 8'd0) begin
                        if (w_last) w_err = ERR_EARLY_LAST;
                        state_d = (code_q == EXEC_PERI_TASK_CODE) ? ST_PERIOD : ST_ARGFLAG;
                    end else begin
                        if (acc_task_q)   w_err = ERR_ACC_NOARGS;
                        else if (!w_last) w_err = ERR_MISSING_LAST;
                        else              w_complete = 1'b1;
                        state_d = ST_HEADER;
                    end
                end
                ST_PERIOD: begin
                    if (nargs_q != 8'd0) begin
                        if (w_last) w_err = ERR_EARLY_LAST;
                        state_d = ST_ARGFLAG;
                    end else begin
                        if (!w_last) w_err = ERR_MISSING_LAST;
                        else         w_complete = 1'b1;
                        state_d = ST_HEADER;
                    end
                end
                ST_ARGFLAG: begin
                    flag_d    = cmdin_tdata[ARG_FLAG_H:ARG_FLAG_L];
                    dir_acc_d = tdest_q;
                    dir_arg_d = arg_idx_q;
                    if (cmdin_tdata[63:32] != {28'b0, arg_idx_q}) w_err = ERR_ARG_IDX;
                    else if (w_last)                              w_err = ERR_EARLY_LAST;
                    state_d = ST_ARG;
                end
                ST_ARG: begin
                    arg_idx_d = arg_idx_q + 4'd1;
                    w_sh_we   = 1'b1;
                    if (w_copy_err != ERR_NONE) w_err = w_copy_err;
                    else if (w_final) begin
                        if (!w_last) w_err = ERR_MISSING_LAST;
                        else         w_complete = 1'b1;
                    end else if (w_last) w_err = ERR_EARLY_LAST;
                    state_d = w_final ? ST_HEADER : ST_ARGFLAG;
                end
                default: begin
                    if (w_last) state_d = ST_HEADER;
                end
            endcase

            if (w_err != ERR_NONE) begin
                state_d = w_last ? ST_HEADER : ST_DRAIN;
            end
        end
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_dest_d  = err_dest_q;
        err_cnt_d   = err_cnt_q;
        cmd_cnt_d   = cmd_cnt_q;
        // A fresh error beats a simultaneous clear
        if (w_err != ERR_NONE) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (!err_valid_q || err_clr) begin
                err_valid_d = 1'b1;
                err_code_d  = w_err;
                err_dest_d  = cmdin_tdest;
            end
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_code_d  = ERR_NONE;
            err_dest_d  = '0;
        end
        if (w_complete) cmd_cnt_d = cmd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_HEADER;
            code_q      <= '0;
            nargs_q     <= '0;
            compf_q     <= '0;
            tdest_q     <= '0;
            acc_task_q  <= 1'b0;
            arg_idx_q   <= '0;
            flag_q      <= '0;
            dir_acc_q   <= '0;
            dir_arg_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_dest_q  <= '0;
            err_cnt_q   <= '0;
            cmd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            nargs_q     <= nargs_d;
            compf_q     <= compf_d;
            tdest_q     <= tdest_d;
            acc_task_q  <= acc_task_d;
            arg_idx_q   <= arg_idx_d;
            flag_q      <= flag_d;
            dir_acc_q   <= dir_acc_d;
            dir_arg_q   <= dir_arg_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_dest_q  <= err_dest_d;
            err_cnt_q   <= err_cnt_d;
            cmd_cnt_q   <= cmd_cnt_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_dest  = err_dest_q;
    assign err_cnt   = err_cnt_q;
    assign cmd_cnt   = cmd_cnt_q;

endmodule

`default_nettype wire
